// File: rtl/led_fader_pkg.sv
// led_fader shared constants and helpers.
// Duty width and idle pad level derive from parameters.
package led_fader_pkg;

  localparam int LEDS = 8;

  function automatic int duty_w(input int pwm_bits);
    return pwm_bits + 1;
  endfunction

  function automatic logic inactive_level(
    input bit active_low
  );
    return active_low;
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED: saturating duty ramp, PWM compare and pad flop.
// Duty spans 0..2^PWM_BITS so fully-on needs no special case.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int FADE_STEP  = 32,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                step,
  input  logic                target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                off_target
);

  localparam int DW = duty_w(PWM_BITS);
  localparam logic [DW-1:0] FULL =
    {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [DW-1:0] STEP_V = DW'(FADE_STEP);

  logic [DW-1:0] duty;
  logic [DW-1:0] duty_nx;
  logic [DW-1:0] goal;
  logic          on;

  assign goal       = target ? FULL : '0;
  assign on         = duty > {1'b0, pwm_cnt};
  assign off_target = duty != goal;

  // Compare remaining distance first so the add/sub never wraps.
  always_comb begin
    duty_nx = duty;
    unique case (1'b1)
      duty < goal:
        duty_nx = (goal - duty <= STEP_V) ?
                  goal : duty + STEP_V;
      duty > goal:
        duty_nx = (duty <= STEP_V) ?
                  '0 : duty - STEP_V;
      default: duty_nx = duty;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= '0;
      led_out <= inactive_level(ACTIVE_LOW);
    end else if (!enable) begin
      duty    <= '0;
      led_out <= inactive_level(ACTIVE_LOW);
    end else begin
      if (step) duty <= duty_nx;
      led_out <= on ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_fader.sv
// Soft-fade PWM driver for the 8-bit LED PIO.
// Shared prescaler/PWM/fade timebase feeds eight channels.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 4,
  parameter int FADE_DIV   = 2,
  parameter int FADE_STEP  = 32,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [LEDS-1:0] led_in,
  output logic [LEDS-1:0] led_out,
  output logic            busy
);

  localparam int PRE_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FD_W =
    (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0] FD_MAX =
    FD_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FD_W-1:0]     fade_cnt;
  logic [LEDS-1:0]     led_in_q;
  logic [LEDS-1:0]     off_tgt;
  logic                tick;
  logic                period_end;
  logic                step;

  assign tick       = pre_cnt == PRE_MAX;
  assign period_end = tick && (pwm_cnt == PWM_MAX);
  assign step       = period_end && (fade_cnt == FD_MAX);
  assign busy       = |off_tgt;

  // Targets keep tracking the PIO even while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_in_q <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      fade_cnt <= '0;
    end else begin
      led_in_q <= led_in;
      if (!enable) begin
        pre_cnt  <= '0;
        pwm_cnt  <= '0;
        fade_cnt <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        if (period_end)
          fade_cnt <= step ? '0 : fade_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LEDS; i++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .step      (step),
      .target    (led_in_q[i]),
      .pwm_cnt   (pwm_cnt),
      .led_out   (led_out[i]),
      .off_target(off_tgt[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: duty is read back as the
// on-count of led_out over one full PWM period after each step.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_ab, rst_c;
  logic       en_a, en_b, en_c;
  logic [7:0] led_a, led_b, led_c;
  logic [7:0] lo_a, lo_b, lo_c;
  logic       busy_a, busy_b, busy_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_fader u_a (
    .clk(clk), .reset_n(rst_ab), .enable(en_a),
    .led_in(led_a), .led_out(lo_a), .busy(busy_a)
  );

  led_fader #(.PRESCALE(1), .FADE_STEP(48)) u_b (
    .clk(clk), .reset_n(rst_ab), .enable(en_b),
    .led_in(led_b), .led_out(lo_b), .busy(busy_b)
  );

  led_fader #(.PRESCALE(1), .ACTIVE_LOW(1)) u_c (
    .clk(clk), .reset_n(rst_c), .enable(en_c),
    .led_in(led_c), .led_out(lo_c), .busy(busy_c)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic stp(input int sel);
    case (sel)
      1: return u_a.step;
      2: return u_b.step;
      default: return u_c.step;
    endcase
  endfunction

  function automatic logic [7:0] lo(input int sel);
    case (sel)
      1: return lo_a;
      2: return lo_b;
      default: return lo_c;
    endcase
  endfunction

  // Wait for the next step, then count led_out[b] high
  // cycles across one PWM period at the new duty.
  task automatic meas(input int sel, input int b,
                      output int hi);
    bit         found;
    logic [7:0] v;
    int         n;
    int         i;
    found = 1'b0;
    i = 0;
    while (!found && i < 2200) begin
      @(negedge clk);
      found = stp(sel);
      i++;
    end
    chk("step_seen", int'(found), 1);
    @(posedge clk);
    @(posedge clk);
    n  = (sel == 1) ? 1024 : 256;
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v = lo(sel);
      hi += int'(v[b]);
    end
  endtask

  task automatic step_chk(input string tag, input int sel,
                          input int b, input int exp);
    int hi;
    meas(sel, b, hi);
    chk(tag, hi, exp);
  endtask

  initial begin
    int bad;
    rst_ab = 1'b0; rst_c = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    led_a = 8'h00; led_b = 8'h00; led_c = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_lo_a", int'(lo_a), 8'h00);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_lo_b", int'(lo_b), 8'h00);
    chk("rst_lo_c", int'(lo_c), 8'hFF);
    chk("rst_busy_c", int'(busy_c), 0);
    rst_ab = 1'b1; rst_c = 1'b1;

    // Idle with all targets off.
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (lo_a !== 8'h00 || busy_a !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Fade bit 0 in, interrupt with a one-cycle disable.
    led_a = 8'h01;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_rise", int'(busy_a), 1);
    for (int k = 1; k <= 3; k++)
      step_chk("a_up_pre", 1, 0, 128 * k);
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_lo", int'(lo_a), 8'h00);
    chk("dis_busy", int'(busy_a), 1);
    en_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step_chk("a_up_full", 1, 0, 128 * k);
      if (k == 7) chk("busy_s7", int'(busy_a), 1);
    end
    chk("busy_done", int'(busy_a), 0);
    bad = 0;
    repeat (1024) begin
      @(negedge clk);
      if (lo_a !== 8'h01) bad++;
    end
    chk("a_full_const", bad, 0);

    // Clear, ramp to 96, then reverse back to 0.
    @(negedge clk);
    led_a = 8'h00;
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b1;
    chk("clr_lo", int'(lo_a), 8'h00);
    chk("clr_busy", int'(busy_a), 0);
    led_a = 8'h01;
    for (int k = 1; k <= 3; k++)
      step_chk("a_up3", 1, 0, 128 * k);
    led_a = 8'h00;
    step_chk("a_dn64", 1, 0, 256);
    step_chk("a_dn32", 1, 0, 128);
    chk("busy_mid_dn", int'(busy_a), 1);
    step_chk("a_dn0", 1, 0, 0);
    chk("busy_dn_done", int'(busy_a), 0);

    // Step of 48 must clamp at full, not wrap.
    led_b = 8'hFF;
    for (int k = 1; k <= 5; k++)
      step_chk("b_up48", 2, 0, 48 * k);
    step_chk("b_clamp", 2, 0, 256);
    chk("b_busy", int'(busy_b), 0);
    bad = 0;
    repeat (256) begin
      @(negedge clk);
      if (lo_b !== 8'hFF) bad++;
    end
    chk("b_full_const", bad, 0);

    // Active-low board: high count is the off time.
    led_c = 8'h80;
    for (int k = 1; k <= 8; k++)
      step_chk("c_up", 3, 7, 256 - 32 * k);
    chk("c_busy", int'(busy_c), 0);
    bad = 0;
    repeat (256) begin
      @(negedge clk);
      if (lo_c !== 8'h7F) bad++;
    end
    chk("c_full_const", bad, 0);
    led_c = 8'h00;
    step_chk("c_dn1", 3, 7, 32);
    step_chk("c_dn2", 3, 7, 64);
    chk("c_busy_mid", int'(busy_c), 1);
    @(negedge clk);
    #2 rst_c = 1'b0;
    #1;
    chk("c_async_lo", int'(lo_c), 8'hFF);
    chk("c_async_busy", int'(busy_c), 0);
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    chk("c_post_rst", int'(lo_c), 8'hFF);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/led_fader.md
# led_fader

Soft-fade PWM driver that sits directly downstream of the 8-bit LED PIO and consumes its `out_port` value. Each bit of the PIO value selects whether one board LED should be fully on or fully off. The block ramps each LED's PWM duty toward that target in fixed steps, producing visible fade-in and fade-out rather than hard switching. It reports when any channel is still mid-fade.

## Interface
- `PWM_BITS`, 8: PWM counter width; duty range is 0..2^PWM_BITS, inclusive.
- `PRESCALE`, 4: clk cycles per PWM tick; must be ≥1.
- `FADE_DIV`, 2: PWM periods per fade step; must be ≥1.
- `FADE_STEP`, 32: duty increment or decrement applied per fade step; must be ≥1.
- `ACTIVE_LOW`, 0: 1 inverts `led_out` for active-low LED boards.

- `clk`  in  1  system clock, same domain as the LED PIO.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  0 forces all LEDs inactive and clears all state (synchronous).
- `led_in`  in  8  target pattern from PIO `out_port`; bit i=1 means LED i on.
- `led_out`  out  8  PWM drive to the pads, registered.
- `busy`  out  1  1 while any channel's duty differs from its target.

## Operation
- `led_in_q`: `led_in` registered once. Fading targets come from `led_in_q` only.
- Prescaler `pre_cnt` counts 0..PRESCALE-1. `tick` is high on the cycle where `pre_cnt==PRESCALE-1`.
- `pwm_cnt` (PWM_BITS wide) increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
- `period_end` = `tick` && `pwm_cnt==2^PWM_BITS-1`.
- `fade_cnt` counts `period_end` events 0..FADE_DIV-1. `step` = `period_end` && `fade_cnt==FADE_DIV-1`.
- Per channel i, `duty[i]` is PWM_BITS+1 bits wide. Target = `led_in_q[i]` ? 2^PWM_BITS : 0.
- On `step`, each channel moves toward its target:
  - If duty < target: duty = min(duty+FADE_STEP, 2^PWM_BITS).
  - If duty > target: duty = max(duty−FADE_STEP, 0), computed without underflow.
  - If duty = target: unchanged.
- Channel on-condition: `duty[i] > pwm_cnt`, with `pwm_cnt` zero-extended. Duty 0 gives never-on; duty 2^PWM_BITS gives always-on.
- `led_out[i]` <= on-condition XOR ACTIVE_LOW.
- `busy` = OR over i of (`duty[i]` != target[i]). It is combinational from registers.
- A target change mid-fade reverses direction from the current duty. The ramp never restarts from 0 or from full.
- `enable`=0, checked each cycle:
  - `pre_cnt`, `pwm_cnt`, `fade_cnt` and all duties go to 0.
  - `led_out` is forced to the inactive level.
  - `led_in_q` still tracks `led_in`.
  - `busy` reflects targets versus the zero duties.
- No handshake with the PIO. Any change of `led_in` is picked up without a strobe.

## Timing
- Reset values:
  - `led_out` = ACTIVE_LOW ? 8'hFF : 8'h00.
  - `busy` = 0.
  - All counters, duties and `led_in_q` = 0.
- Reset asserted mid-fade: immediate return to the reset values above. Counting restarts from 0 after release.
- `led_in` change sampled at edge k appears in `led_in_q` at edge k+1. `busy` can rise after edge k+1.
- The first duty change happens at the next `step`, at most PRESCALE·2^PWM_BITS·FADE_DIV cycles later (2048 with defaults).
- `led_out` lags `pwm_cnt`/duty by 1 cycle.
- With defaults:
  - PWM period = 1024 clk.
  - Step interval = 2048 clk.
  - Full fade = 8 steps = 16384 clk.
- `enable` low takes effect at the next edge. `led_out` is inactive one cycle after `enable` is sampled low.

## Structure
- Package `led_fader_pkg` holds:
  - `DUTY_W` = PWM_BITS+1, expressed as a function of the parameter.
  - A helper function giving the inactive level from ACTIVE_LOW.
- Sub-module `led_fader_channel`:
  - Contains one duty register, the saturating step logic, the compare and the output flop.
  - Instantiated 8 times by a generate loop.
  - Shared `tick`, `pwm_cnt` and `step` come from the top.
- The top level holds the prescaler, PWM and fade counters, `led_in_q`, and the `busy` reduction.

## Test plan
1. Reset with `led_in`=0x00 and `enable`=1 → `led_out`=0x00 and `busy`=0 throughout 5000 cycles.
2. `led_in`=0x01 → `busy`=1 from cycle 2.
   - After the first step, `led_out[0]` is high for 128 of each 1024 cycles.
   - After 8 steps, `led_out[0]` is constantly 1 and `busy`=0. `led_out[7:1]` stays 0.
3. Fade bit 0 in to duty 96 (3 steps), then set `led_in`=0x00 → duty goes 64, 32, 0 on the next 3 steps. `busy` falls once duty reaches 0.
4. Mid-fade, pull `enable` low for 1 cycle, then restore it:
   - `led_out`=0x00 on the next cycle.
   - All duties are 0.
   - The ramp restarts from 0 and needs a full 8 steps.
5. Set `FADE_STEP`=48, `led_in`=0xFF → duties follow 48, 96, …, 240, then clamp at 256 (no wrap). All `led_out` bits are constantly 1 after 6 steps.
6. Set `ACTIVE_LOW`=1:
   - Reset gives `led_out`=0xFF.
   - A full fade-in of 0x80 gives `led_out`=0x7F steady.
   - Async reset asserted mid-fade returns 0xFF immediately.
